control_desplazamiento: RTL

//   Sequencer for the universal shift register built from serialOcontiguo cells.
//   - Accepts one command at a time over a valid/ready handshake: parallel load,

---
 rtl/control_desplazamiento.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/control_desplazamiento.sv
// Sequencer for a universal shift register: accepts load/shift/rotate commands
// over valid/ready, drives the shared modo bus and the serial input, then pulses done.
module control_desplazamiento #(
  parameter int         WIDTH      = 4,
  parameter int         CNT_W      = 4,
  parameter logic [1:0] MODO_HOLD  = 2'b00,
  parameter logic [1:0] MODO_DER   = 2'b01,
  parameter logic [1:0] MODO_IZQ   = 2'b10,
  parameter logic [1:0] MODO_CARGA = 2'b11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_serial,
  input  logic             q_lsb,
  output logic [1:0]       modo,
  output logic             s_in,
  output logic             busy,
  output logic             done
);

  localparam int               PTR_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WIDTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] OP_CARGA = 2'b00;
  localparam logic [1:0] OP_IZQ   = 2'b10;
  localparam logic [1:0] OP_ROT   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CARGA = 2'b01,
    SHIFT = 2'b10,
    FIN   = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       modo_q, modo_d;
  logic             s_in_q, s_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] serial_q, serial_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic accept;

  assign cmd_ready = (state_q == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;

  // rem_q counts shifts still to issue, so a full-scale count never has to
  // represent cnt+1; ptr_q walks the serial pattern modulo WIDTH.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    serial_d = serial_q;
    rem_d    = rem_q;
    ptr_d    = ptr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d     = cmd_op;
          serial_d = cmd_serial;
          rem_d    = cmd_cnt;
          ptr_d    = '0;
          if (cmd_op == OP_CARGA) begin
            state_d = CARGA;
          end else if (cmd_cnt == '0) begin
            state_d = FIN;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      CARGA: state_d = FIN;
      SHIFT: begin
        rem_d = rem_q - CNT_ONE;
        ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_ONE;
        if (rem_q == CNT_ONE) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they come out of flops
    // aligned with the state they describe.
    modo_d = MODO_HOLD;
    s_in_d = 1'b0;
    case (state_d)
      CARGA: modo_d = MODO_CARGA;
      SHIFT: begin
        modo_d = (op_d == OP_IZQ) ? MODO_IZQ : MODO_DER;
        if (op_d != OP_ROT) begin
          s_in_d = serial_d[ptr_d];
        end
      end
      default: modo_d = MODO_HOLD;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      modo_q  <= MODO_HOLD;
      s_in_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      modo_q  <= modo_d;
      s_in_q  <= s_in_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Command fields are only meaningful after an accept reloads them.
  always_ff @(posedge clk) begin
    op_q     <= op_d;
    serial_q <= serial_d;
    rem_q    <= rem_d;
    ptr_q    <= ptr_d;
  end

  assign modo = modo_q;
  assign busy = busy_q;
  assign done = done_q;
  // Rotation feeds bit 0 straight back so it tracks the register every cycle.
  assign s_in = ((state_q == SHIFT) && (op_q == OP_ROT)) ? q_lsb : s_in_q;

endmodule
